// File: rtl/axi_stream_tlast_regen_pkg.sv
// Shared axis definitions: FSM state encoding and the default descriptor width
// used by the length-descriptor FIFOs and the tlast regenerator.
package axi_stream_tlast_regen_pkg;

   localparam int AXIS_LSIZE_DEF = 32;

   typedef enum logic [0:0] {
      AXIS_IDLE = 1'b0,
      AXIS_RUN  = 1'b1
   } axis_state_e;

endpackage

// File: rtl/axi_stream_tlast_regen_if.sv
// Descriptor, untagged input and framed output channels of the tlast regenerator.
interface axi_stream_tlast_regen_if
   import axi_stream_tlast_regen_pkg::*;
#(
   parameter int DSIZE = 64,
   parameter int KSIZE = DSIZE / 8,
   parameter int LSIZE = AXIS_LSIZE_DEF
) ();

   logic             len_tvalid;
   logic             len_tready;
   logic [LSIZE-1:0] len_tdata;

   logic             in_tvalid;
   logic             in_tready;
   logic [DSIZE-1:0] in_tdata;
   logic [KSIZE-1:0] in_tkeep;
   logic             in_tuser;

   logic             out_tvalid;
   logic             out_tready;
   logic [DSIZE-1:0] out_tdata;
   logic [KSIZE-1:0] out_tkeep;
   logic             out_tuser;
   logic             out_tlast;

   modport master (
      output len_tvalid, len_tdata,
      input  len_tready,
      output in_tvalid, in_tdata, in_tkeep, in_tuser,
      input  in_tready,
      input  out_tvalid, out_tdata, out_tkeep, out_tuser, out_tlast,
      output out_tready
   );

   modport slave (
      input  len_tvalid, len_tdata,
      output len_tready,
      input  in_tvalid, in_tdata, in_tkeep, in_tuser,
      output in_tready,
      output out_tvalid, out_tdata, out_tkeep, out_tuser, out_tlast,
      input  out_tready
   );

endinterface

// File: rtl/axi_stream_tlast_regen_out_slice.sv
// One-deep valid/ready output register; payload only loads when the slot is
// free or draining this cycle, so a stalled beat is held stable.
module axis_out_reg_slice #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] dout,
   output logic         stall_free
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = din;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid  = valid_q;
   assign dout       = data_q;
   assign stall_free = !valid_q || out_ready;

endmodule

// File: rtl/axi_stream_tlast_regen.sv
// Regenerates tlast on an untagged data stream from a beats-minus-one length
// descriptor; one descriptor held at a time, next one taken on the last beat.
module axi_stream_tlast_regen
   import axi_stream_tlast_regen_pkg::*;
#(
   parameter int DSIZE = 64,
   parameter int KSIZE = DSIZE / 8,
   parameter int LSIZE = AXIS_LSIZE_DEF
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   axi_stream_tlast_regen_if.slave  s,
   output logic [31:0]              pkt_cnt
);

   localparam logic [0:0] IDLE = AXIS_IDLE;
   localparam logic [0:0] RUN  = AXIS_RUN;
   localparam int         PW   = DSIZE + KSIZE + 2;

   logic [0:0]       state_q, state_d;
   logic [LSIZE-1:0] cnt_q, cnt_d;
   logic [LSIZE-1:0] len_q, len_d;
   logic [31:0]      pkt_cnt_q, pkt_cnt_d;

   logic          stall_free;
   logic          in_tready, in_fire, last_in;
   logic          len_tready, len_fire;
   logic [PW-1:0] pay_in, pay_out;

   assign in_tready  = (state_q == RUN) && stall_free;
   assign in_fire    = s.in_tvalid && in_tready;
   assign last_in    = in_fire && (cnt_q == len_q);
   // Taking the next descriptor on the last beat avoids a bubble between packets.
   assign len_tready = (state_q == IDLE) || last_in;
   assign len_fire   = s.len_tvalid && len_tready;

   assign s.in_tready  = in_tready;
   assign s.len_tready = len_tready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      case (state_q)
         IDLE: begin
            if (len_fire) begin
               state_d = RUN;
               len_d   = s.len_tdata;
               cnt_d   = '0;
            end
         end
         default: begin
            if (last_in) begin
               cnt_d = '0;
               if (len_fire) len_d   = s.len_tdata;
               else          state_d = IDLE;
            end else if (in_fire) begin
               cnt_d = cnt_q + LSIZE'(1);
            end
         end
      endcase
   end

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (s.out_tvalid && s.out_tready && s.out_tlast) pkt_cnt_d = pkt_cnt_q + 32'd1;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         len_q     <= '0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   assign pkt_cnt = pkt_cnt_q;

   assign pay_in = {s.in_tuser, s.in_tkeep, s.in_tdata, last_in};

   axis_out_reg_slice #(.W(PW)) u_out (
      .clk        (aclk),
      .rst_n      (aresetn),
      .load       (in_fire),
      .din        (pay_in),
      .out_ready  (s.out_tready),
      .out_valid  (s.out_tvalid),
      .dout       (pay_out),
      .stall_free (stall_free)
   );

   assign {s.out_tuser, s.out_tkeep, s.out_tdata, s.out_tlast} = pay_out;

endmodule

// File: tb/tb_axi_stream_tlast_regen.sv
// Randomised and directed bench; a cumulative-beat model decides readiness,
// framing and the expected output beat on every cycle.
module tb_axi_stream_tlast_regen;

   localparam int DSIZE = 64;
   localparam int KSIZE = 8;
   localparam int LSIZE = 32;

   typedef struct packed {
      logic [DSIZE-1:0] d;
      logic [KSIZE-1:0] k;
      logic             u;
      logic             l;
   } beat_t;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [31:0] pkt_cnt;

   axi_stream_tlast_regen_if #(.DSIZE(DSIZE), .KSIZE(KSIZE), .LSIZE(LSIZE)) bus ();

   axi_stream_tlast_regen #(.DSIZE(DSIZE), .KSIZE(KSIZE), .LSIZE(LSIZE)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s       (bus),
      .pkt_cnt (pkt_cnt)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // model state: rem = descriptor beats accepted minus data beats accepted
   longint      rem = 0;
   beat_t       exp_q[$];
   beat_t       obs_q[$];
   int          in_cyc_q[$];
   int          out_cyc_q[$];
   logic [31:0] pkt_m = 0;
   int          cyc = 0;

   always @(negedge aclk) begin
      logic  e_in_rdy, e_len_rdy, df, lf, of;
      beat_t b;
      cyc++;
      if (!aresetn) begin
         rem = 0;
         exp_q.delete();
         pkt_m = 0;
      end else begin
         e_in_rdy  = (rem > 0) && (exp_q.size() == 0 || bus.out_tready);
         e_len_rdy = (rem == 0) || (rem == 1 && bus.in_tvalid && e_in_rdy);
         chk("in_tready", bus.in_tready, e_in_rdy);
         chk("len_tready", bus.len_tready, e_len_rdy);
         chk("out_tvalid", bus.out_tvalid, exp_q.size() != 0);
         chk("pkt_cnt", pkt_cnt, pkt_m);
         if (exp_q.size() != 0) begin
            chk("out_tdata", bus.out_tdata, exp_q[0].d);
            chk("out_tkeep", bus.out_tkeep, exp_q[0].k);
            chk("out_tuser", bus.out_tuser, exp_q[0].u);
            chk("out_tlast", bus.out_tlast, exp_q[0].l);
         end
         df = bus.in_tvalid && e_in_rdy;
         lf = bus.len_tvalid && e_len_rdy;
         of = bus.out_tready && exp_q.size() != 0;
         if (of) begin
            obs_q.push_back({bus.out_tdata, bus.out_tkeep, bus.out_tuser, bus.out_tlast});
            out_cyc_q.push_back(cyc);
            if (exp_q[0].l) pkt_m = pkt_m + 32'd1;
            void'(exp_q.pop_front());
         end
         if (df) begin
            b = '{d: bus.in_tdata, k: bus.in_tkeep, u: bus.in_tuser, l: (rem == 1)};
            exp_q.push_back(b);
            in_cyc_q.push_back(cyc);
            rem = rem - 1;
         end
         if (lf) rem = rem + longint'(bus.len_tdata) + 1;
      end
   end

   logic [LSIZE-1:0] desc_q[$];
   beat_t            data_q[$];

   task automatic clear_logs();
      obs_q.delete();
      in_cyc_q.delete();
      out_cyc_q.delete();
   endtask

   // rdy_mode: 0 always ready, 1 toggling, 2 random
   task automatic run(input int max_cyc, input int rdy_mode, input int pvalid,
                      input int desc_delay, input int stop_in);
      int n = 0;
      int ins = 0;
      logic lf, df;
      while (n < max_cyc) begin
         @(negedge aclk);
         lf = bus.len_tvalid && bus.len_tready;
         df = bus.in_tvalid && bus.in_tready;
         @(posedge aclk);
         #1;
         if (lf) void'(desc_q.pop_front());
         if (df) begin
            void'(data_q.pop_front());
            ins++;
         end
         if (stop_in != 0 && ins >= stop_in) return;
         if (!(bus.len_tvalid && !lf)) begin
            bus.len_tvalid = 1'b0;
            if (desc_q.size() != 0 && n >= desc_delay && $urandom_range(99) < pvalid) begin
               bus.len_tvalid = 1'b1;
               bus.len_tdata  = desc_q[0];
            end
         end
         if (!(bus.in_tvalid && !df)) begin
            bus.in_tvalid = 1'b0;
            if (data_q.size() != 0 && $urandom_range(99) < pvalid) begin
               bus.in_tvalid = 1'b1;
               bus.in_tdata  = data_q[0].d;
               bus.in_tkeep  = data_q[0].k;
               bus.in_tuser  = data_q[0].u;
            end
         end
         case (rdy_mode)
            0:       bus.out_tready = 1'b1;
            1:       bus.out_tready = (n % 2 == 0);
            default: bus.out_tready = ($urandom_range(3) != 0);
         endcase
         n++;
         if (desc_q.size() == 0 && data_q.size() == 0 && !bus.len_tvalid &&
             !bus.in_tvalid && exp_q.size() == 0) return;
      end
      chk("run_timeout", 64'(n), 64'(max_cyc + 1));
   endtask

   task automatic push_data(input logic [63:0] v);
      beat_t b;
      b = '{d: v, k: v[7:0] ^ 8'h3C, u: v[0], l: 1'b0};
      data_q.push_back(b);
   endtask

   initial begin
      int total;
      aresetn        = 1'b0;
      bus.len_tvalid = 1'b0;
      bus.len_tdata  = '0;
      bus.in_tvalid  = 1'b0;
      bus.in_tdata   = '0;
      bus.in_tkeep   = '0;
      bus.in_tuser   = 1'b0;
      bus.out_tready = 1'b0;
      #1;
      chk("rst_out_tvalid", bus.out_tvalid, 1'b0);
      chk("rst_out_tlast", bus.out_tlast, 1'b0);
      chk("rst_out_tdata", bus.out_tdata, 64'h0);
      chk("rst_out_tkeep", bus.out_tkeep, 8'h0);
      chk("rst_pkt_cnt", pkt_cnt, 32'd0);
      chk("rst_len_tready", bus.len_tready, 1'b1);
      chk("rst_in_tready", bus.in_tready, 1'b0);
      #21 aresetn = 1'b1;

      // single-beat packet, one-cycle latency
      clear_logs();
      desc_q.push_back(0);
      push_data(64'hA5);
      run(50, 0, 100, 0, 0);
      chk("t1_beats", obs_q.size(), 1);
      if (obs_q.size() == 1) begin
         chk("t1_data", obs_q[0].d, 64'hA5);
         chk("t1_last", obs_q[0].l, 1'b1);
         chk("t1_latency", out_cyc_q[0] - in_cyc_q[0], 1);
      end
      chk("t1_pkt_cnt", pkt_cnt, 32'd1);

      // four-beat packet, tlast only on the fourth
      clear_logs();
      desc_q.push_back(3);
      for (int i = 1; i <= 4; i++) push_data(64'(i));
      run(50, 0, 100, 0, 0);
      chk("t2_beats", obs_q.size(), 4);
      for (int i = 0; i < obs_q.size(); i++) begin
         chk("t2_data", obs_q[i].d, 64'(i + 1));
         chk("t2_last", obs_q[i].l, i == 3);
      end
      chk("t2_idle_len_tready", bus.len_tready, 1'b1);

      // back-to-back packets 2 + 3 beats, no gap
      clear_logs();
      desc_q.push_back(1);
      desc_q.push_back(2);
      for (int i = 1; i <= 5; i++) push_data(64'(i));
      run(50, 0, 100, 0, 0);
      chk("t3_beats", obs_q.size(), 5);
      for (int i = 0; i < obs_q.size(); i++) chk("t3_last", obs_q[i].l, i == 1 || i == 4);
      if (in_cyc_q.size() == 5) chk("t3_no_bubble", in_cyc_q[4] - in_cyc_q[0], 4);
      chk("t3_pkt_cnt", pkt_cnt, 32'd4);

      // toggling downstream ready
      clear_logs();
      desc_q.push_back(3);
      for (int i = 1; i <= 4; i++) push_data(64'(16 * i));
      run(80, 1, 100, 0, 0);
      chk("t4_beats", obs_q.size(), 4);
      for (int i = 0; i < obs_q.size(); i++) begin
         chk("t4_data", obs_q[i].d, 64'(16 * (i + 1)));
         chk("t4_last", obs_q[i].l, i == 3);
      end

      // data waits for a late descriptor
      clear_logs();
      desc_q.push_back(1);
      push_data(64'h77);
      push_data(64'h88);
      run(50, 0, 100, 5, 0);
      chk("t5_beats", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         chk("t5_last0", obs_q[0].l, 1'b0);
         chk("t5_last1", obs_q[1].l, 1'b1);
      end

      // reset in the middle of an eight-beat packet
      clear_logs();
      desc_q.push_back(7);
      for (int i = 1; i <= 8; i++) push_data(64'(i + 100));
      run(50, 0, 100, 0, 2);
      @(posedge aclk);
      #3 aresetn = 1'b0;
      #1;
      chk("t6_out_tvalid", bus.out_tvalid, 1'b0);
      chk("t6_out_tlast", bus.out_tlast, 1'b0);
      chk("t6_pkt_cnt", pkt_cnt, 32'd0);
      chk("t6_len_tready", bus.len_tready, 1'b1);
      chk("t6_in_tready", bus.in_tready, 1'b0);
      bus.len_tvalid = 1'b0;
      bus.in_tvalid  = 1'b0;
      desc_q.delete();
      data_q.delete();
      repeat (2) @(posedge aclk);
      #3 aresetn = 1'b1;
      clear_logs();
      desc_q.push_back(0);
      push_data(64'h5A);
      run(50, 0, 100, 0, 0);
      chk("t6_beats", obs_q.size(), 1);
      if (obs_q.size() == 1) begin
         chk("t6_data", obs_q[0].d, 64'h5A);
         chk("t6_last", obs_q[0].l, 1'b1);
      end

      // random traffic
      clear_logs();
      total = 0;
      for (int p = 0; p < 40; p++) begin
         int len;
         len = $urandom_range(5);
         desc_q.push_back(LSIZE'(len));
         total += len + 1;
         for (int i = 0; i <= len; i++) push_data({$urandom, $urandom});
      end
      run(5000, 2, 60, 0, 0);
      chk("rnd_beats", obs_q.size(), total);
      chk("rnd_pkt_cnt", pkt_cnt, 32'd41);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
